// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, majority-voted mid-bit sampling, valid/ready output register.
// Optional even-parity (8E1) build enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       resn,
  input  logic       serialIn,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       clear_err
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUB_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] MID_LO   = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] MID      = SUB_W'(OVERSAMPLE / 2);
  localparam logic [SUB_W-1:0] MID_HI   = SUB_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state, next_state;
  logic               sync1, line;
  logic [DIV_W-1:0]   div_cnt;
  logic [SUB_W-1:0]   sub_cnt;
  logic               samp_a, samp_b;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               tick, start_edge, sample_evt, maj;
  logic               shift_en, complete, frame_set, par_set;

  assign tick       = (div_cnt == DIV_LAST);
  assign start_edge = (state == S_IDLE) && !line;
  assign sample_evt = tick && (sub_cnt == MID_HI);
  // The third vote is the live synced line at the MID_HI tick itself.
  assign maj        = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    complete   = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
    case (state)
      S_IDLE:  if (!line) next_state = S_START;
      S_START: if (sample_evt) next_state = maj ? S_IDLE : S_DATA;
      S_DATA: begin
        if (sample_evt) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) next_state = S_PARITY;
`else
          if (bit_idx == 3'd7) next_state = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_evt) begin
          par_set    = (maj != ^shreg);
          next_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample_evt) begin
          if (maj) begin
            complete   = 1'b1;
            next_state = S_IDLE;
          end else begin
            frame_set  = 1'b1;
            next_state = S_BREAK;
          end
        end
      end
      S_BREAK: if (line) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sync1   <= 1'b1;
      line    <= 1'b1;
      div_cnt <= '0;
      sub_cnt <= '0;
      samp_a  <= 1'b0;
      samp_b  <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync1 <= serialIn;
      line  <= sync1;
      // Reload on the start edge so the sub-bit phase is anchored to the falling edge.
      if (start_edge || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + DIV_W'(1);
      if (state == S_IDLE)    sub_cnt <= '0;
      else if (tick)          sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
      if (tick && sub_cnt == MID_LO) samp_a <= line;
      if (tick && sub_cnt == MID)    samp_b <= line;
      if (state == S_START)   bit_idx <= '0;
      else if (shift_en)      bit_idx <= bit_idx + 3'd1;
      if (shift_en)           shreg   <= {maj, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // Clear first so a same-cycle set event takes precedence.
      if (clear_err) begin
        frame_err <= 1'b0;
        if (!(complete && rx_valid && !rx_ready)) overrun <= 1'b0;
      end
      if (frame_set) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if (clear_err) parity_err <= 1'b0;
      if (par_set)   parity_err <= 1'b1;
`endif
    end
  end

endmodule
